// File: rtl/exc_resolve_if.sv
// ---------------------------------------------------------------------------
// exc_resolve_if
//   Signal bundle between the MEM-stage exception resolver and its neighbours.
//   master : the pipeline/CP0 side. It drives the exception flags, the MEM PC,
//            the CP0 register values and the WB-stage CP0 write. It receives
//            the flush/redirect and the values CP0 records.
//   slave  : the resolver (exc_resolve).
// ---------------------------------------------------------------------------
interface exc_resolve_if;
    // Pipeline / CP0 -> resolver
    logic [31:0] excepttype_i;
    logic [31:0] current_inst_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] cp0_status_i;
    logic [31:0] cp0_cause_i;
    logic [31:0] cp0_epc_i;
    logic        wb_cp0_reg_we_i;
    logic [4:0]  wb_cp0_reg_write_addr_i;
    logic [31:0] wb_cp0_reg_data_i;

    // Resolver -> pipeline / CP0
    logic [31:0] excepttype_o;
    logic [4:0]  exc_code_o;
    logic [31:0] exc_epc_o;
    logic        exc_bd_o;
    logic [31:0] cp0_epc_o;
    logic        flush_o;
    logic [31:0] new_pc_o;

    modport master (
        output excepttype_i, current_inst_addr_i, is_in_delayslot_i,
               cp0_status_i, cp0_cause_i, cp0_epc_i,
               wb_cp0_reg_we_i, wb_cp0_reg_write_addr_i, wb_cp0_reg_data_i,
        input  excepttype_o, exc_code_o, exc_epc_o, exc_bd_o,
               cp0_epc_o, flush_o, new_pc_o
    );

    modport slave (
        input  excepttype_i, current_inst_addr_i, is_in_delayslot_i,
               cp0_status_i, cp0_cause_i, cp0_epc_i,
               wb_cp0_reg_we_i, wb_cp0_reg_write_addr_i, wb_cp0_reg_data_i,
        output excepttype_o, exc_code_o, exc_epc_o, exc_bd_o,
               cp0_epc_o, flush_o, new_pc_o
    );
endinterface

// File: rtl/exc_resolve.sv
// ---------------------------------------------------------------------------
// exc_resolve
//   Precise-exception resolver for the MEM stage. It merges the exception
//   flags carried by the MEM instruction with the pending-interrupt condition
//   taken from CP0 Status/Cause. It picks the highest-priority exception and
//   registers a one-cycle flush with the redirect PC. It also registers the
//   ExcCode/EPC/BD values that CP0 records.
//
//   Ports
//     clk  : clock
//     rst  : synchronous reset, active-high
//     bus  : exc_resolve_if.slave
//       inputs : excepttype_i, current_inst_addr_i, is_in_delayslot_i,
//                cp0_status_i, cp0_cause_i, cp0_epc_i,
//                wb_cp0_reg_we_i, wb_cp0_reg_write_addr_i, wb_cp0_reg_data_i
//       outputs: excepttype_o, exc_code_o, exc_epc_o, exc_bd_o (registered),
//                flush_o, new_pc_o (registered),
//                cp0_epc_o (combinational, forwarded EPC)
//
//   Build option
//     EXC_CP0_FWD_EN : when defined, a same-cycle WB-stage CP0 write to
//                      Status/Cause/EPC overrides the CP0 register outputs.
//                      When undefined, the raw CP0 values are used and the
//                      wb_cp0_* inputs are ignored.
// ---------------------------------------------------------------------------
module exc_resolve (
    input  logic          clk,
    input  logic          rst,
    exc_resolve_if.slave  bus
);
    localparam logic [4:0]  CP0_STATUS  = 5'd12;
    localparam logic [4:0]  CP0_CAUSE   = 5'd13;
    localparam logic [4:0]  CP0_EPC     = 5'd14;
    localparam logic [31:0] HANDLER_PC  = 32'h0000_0020;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLUSH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [31:0] status, cause, epc;

    // ---------------- CP0 forwarding ----------------
`ifdef EXC_CP0_FWD_EN
    always_comb begin
        status = bus.cp0_status_i;
        cause  = bus.cp0_cause_i;
        epc    = bus.cp0_epc_i;
        if (bus.wb_cp0_reg_we_i) begin
            case (bus.wb_cp0_reg_write_addr_i)
                CP0_STATUS: status = bus.wb_cp0_reg_data_i;
                // Only IP[1:0], IV and WP are software-writable in Cause.
                CP0_CAUSE: begin
                    cause[9:8] = bus.wb_cp0_reg_data_i[9:8];
                    cause[22]  = bus.wb_cp0_reg_data_i[22];
                    cause[23]  = bus.wb_cp0_reg_data_i[23];
                end
                CP0_EPC:    epc = bus.wb_cp0_reg_data_i;
                default: ;
            endcase
        end
    end
`else
    assign status = bus.cp0_status_i;
    assign cause  = bus.cp0_cause_i;
    assign epc    = bus.cp0_epc_i;

    logic unused_wb;
    assign unused_wb = &{1'b0, bus.wb_cp0_reg_we_i, bus.wb_cp0_reg_write_addr_i,
                         bus.wb_cp0_reg_data_i, CP0_STATUS, CP0_CAUSE, CP0_EPC};
`endif

    assign bus.cp0_epc_o = epc;

    // Register bits that play no part in exception selection.
    logic unused_bits;
    assign unused_bits = &{1'b0, status[31:16], status[7:2], cause[31:16],
                           cause[7:0], bus.excepttype_i[31:13],
                           bus.excepttype_i[7:0]};

    // ---------------- detection / next-state ----------------
    logic        inst_valid, int_pending;
    logic [31:0] type_next, epc_next, pc_next;
    logic [4:0]  code_next;
    logic        bd_next, flush_next;

    assign inst_valid  = (bus.current_inst_addr_i != 32'd0);
    assign int_pending = (|(cause[15:8] & status[15:8])) && !status[1] &&
                         status[0] && inst_valid;

    // NOTE: every always_comb output gets a default first, so no path can leave it
    // holding a stale value and infer a latch.
    always_comb begin
        state_next = state;
        type_next  = 32'd0;
        code_next  = 5'd0;
        epc_next   = 32'd0;
        bd_next    = 1'b0;
        flush_next = 1'b0;
        pc_next    = 32'd0;

        case (state)
            S_IDLE: begin
                if (inst_valid) begin
                    if (int_pending)                 begin type_next = 32'h1; code_next = 5'd0;  end
                    else if (bus.excepttype_i[8])    begin type_next = 32'h8; code_next = 5'd8;  end
                    else if (bus.excepttype_i[9])    begin type_next = 32'ha; code_next = 5'd10; end
                    else if (bus.excepttype_i[10])   begin type_next = 32'hd; code_next = 5'd13; end
                    else if (bus.excepttype_i[11])   begin type_next = 32'hc; code_next = 5'd12; end
                    else if (bus.excepttype_i[12])   begin type_next = 32'he; code_next = 5'd0;  end
                end

                if (type_next == 32'he) begin
                    // ERET returns to the forwarded EPC and records nothing.
                    flush_next = 1'b1;
                    pc_next    = epc;
                    state_next = S_FLUSH;
                end else if (type_next != 32'd0) begin
                    flush_next = 1'b1;
                    pc_next    = HANDLER_PC;
                    bd_next    = bus.is_in_delayslot_i;
                    // A delay-slot instruction restarts at its branch.
                    epc_next   = bus.is_in_delayslot_i ? bus.current_inst_addr_i - 32'd4
                                                       : bus.current_inst_addr_i;
                    state_next = S_FLUSH;
                end
            end
            S_FLUSH: state_next = S_HOLD;
            S_HOLD:  state_next = S_IDLE;   // the pipe holds a bubble here
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- registers ----------------
    logic [31:0] type_q, epc_q, pc_q;
    logic [4:0]  code_q;
    logic        bd_q, flush_q;

    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values from before the edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            type_q  <= 32'd0;
            code_q  <= 5'd0;
            epc_q   <= 32'd0;
            bd_q    <= 1'b0;
            flush_q <= 1'b0;
            pc_q    <= 32'd0;
        end else begin
            state   <= state_next;
            type_q  <= type_next;
            code_q  <= code_next;
            epc_q   <= epc_next;
            bd_q    <= bd_next;
            flush_q <= flush_next;
            pc_q    <= pc_next;
        end
    end

    assign bus.excepttype_o = type_q;
    assign bus.exc_code_o   = code_q;
    assign bus.exc_epc_o    = epc_q;
    assign bus.exc_bd_o     = bd_q;
    assign bus.flush_o      = flush_q;
    assign bus.new_pc_o     = pc_q;
endmodule
